wb_arbiter: RTL and testbench

- Writeback stage that produces the single register-file write port (reg_write, rd, rd_data) from two result sources:
  - single-cycle ALU results;
  - variable-latency load returns.
- Load returns are buffered in a small FIFO and arbitrated against ALU results. ALU results always win the write port.
- A load scoreboard tracks registers with outstanding loads and gives the issue stage a combinational stall flag.

---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered load returns
// onto one register-file write port. ALU results always take the port; load
// returns wait in a small FIFO. A load scoreboard marks registers whose load
// has not yet been written back and raises a combinational stall for issue.
module wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [REG_AW-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [REG_AW-1:0]         ld_rd,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      ld_issue,
  input  logic [REG_AW-1:0]         ld_issue_rd,
  input  logic [REG_AW-1:0]         chk_rs1,
  input  logic [REG_AW-1:0]         chk_rs2,
  output logic                      stall,
  output logic [(2**REG_AW)-1:0]    pending,
  output logic                      reg_write,
  output logic [REG_AW-1:0]         rd,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  localparam int NREG  = 2 ** REG_AW;
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

  logic [REG_AW-1:0] q_rd   [LQ_DEPTH];
  logic [DATA_W-1:0] q_data [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ready_en;
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_next;
  logic              push;
  logic              pop;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  // ready_en keeps ld_ready low during reset and for the cycle it is released
  assign ld_ready  = ready_en && (count < DEPTH_C);
  assign push      = ld_valid && ld_ready;
  assign pop       = !alu_valid && (count != '0);
  assign head_rd   = q_rd[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign lq_count  = count;
  assign pending   = pending_q;
  assign stall     = pending_q[chk_rs1] | pending_q[chk_rs2];

  // Enable load acceptance from the first clock edge after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // Load-return FIFO: storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_rd[wr_ptr]   <= ld_rd;
        q_data[wr_ptr] <= ld_data;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Next scoreboard state: a pop clears its register, a new issue sets (and wins)
  always_comb begin
    pending_next = pending_q;
    if (pop) pending_next[head_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) pending_next[ld_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_next;
  end

  // Write-port register: ALU first, then FIFO head; r0 writes consume the slot silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
    end else if (alu_valid) begin
      reg_write <= (alu_rd != '0);
      rd        <= alu_rd;
      rd_data   <= alu_data;
    end else if (pop) begin
      reg_write <= (head_rd != '0);
      rd        <= head_rd;
      rd_data   <= head_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a table of per-cycle stimulus with the
// expected post-edge state, fed through a scoreboard queue, plus a hand-written
// reset-in-flight sequence.
module tb_wb_arbiter;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int LQ_DEPTH = 2;
  localparam int NREG     = 16;
  localparam int CNT_W    = 2;
  localparam int NVEC     = 26;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_issue;
  logic [REG_AW-1:0] ld_issue_rd;
  logic [REG_AW-1:0] chk_rs1;
  logic [REG_AW-1:0] chk_rs2;
  logic              stall;
  logic [NREG-1:0]   pending;
  logic              reg_write;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  lq_count;

  typedef struct {
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              rdy;
    logic              stall;
    logic [NREG-1:0]   pend;
  } exp_t;

  typedef struct {
    logic              av;
    logic [REG_AW-1:0] ard;
    logic [DATA_W-1:0] adata;
    logic              lv;
    logic [REG_AW-1:0] lrd;
    logic [DATA_W-1:0] ldata;
    logic              li;
    logic [REG_AW-1:0] lird;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    exp_t              e;
  } vec_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   assertions = 0;
  int   failures   = 0;

  wb_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall), .pending(pending),
    .reg_write(reg_write), .rd(rd), .rd_data(rd_data), .lq_count(lq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic av, input logic [3:0] ard, input logic [15:0] adata,
    input logic lv, input logic [3:0] lrd, input logic [15:0] ldata,
    input logic li, input logic [3:0] lird,
    input logic [3:0] rs1, input logic [3:0] rs2,
    input logic wr, input logic [3:0] erd, input logic [15:0] edata,
    input logic [1:0] cnt, input logic rdy, input logic st, input logic [15:0] pend);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.li = li; v.lird = lird; v.rs1 = rs1; v.rs2 = rs2;
    v.e.wr = wr; v.e.rd = erd; v.e.data = edata; v.e.cnt = cnt;
    v.e.rdy = rdy; v.e.stall = st; v.e.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveIdle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    ld_issue = 0; ld_issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
    ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldata;
    ld_issue = v.li; ld_issue_rd = v.lird;
    chk_rs1 = v.rs1; chk_rs2 = v.rs2;
    sb_q.push_back(v.e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      check($sformatf("v%0d_scoreboard_empty", idx), 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check($sformatf("v%0d_reg_write", idx), 32'(reg_write), 32'(e.wr));
    check($sformatf("v%0d_rd", idx),        32'(rd),        32'(e.rd));
    check($sformatf("v%0d_rd_data", idx),   32'(rd_data),   32'(e.data));
    check($sformatf("v%0d_lq_count", idx),  32'(lq_count),  32'(e.cnt));
    check($sformatf("v%0d_ld_ready", idx),  32'(ld_ready),  32'(e.rdy));
    check($sformatf("v%0d_stall", idx),     32'(stall),     32'(e.stall));
    check($sformatf("v%0d_pending", idx),   32'(pending),   32'(e.pend));
  endtask

  initial begin
    //             av ard  adata    lv lrd ldata    li lird rs1 rs2 | wr rd  data     cnt rdy st pend
    vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 16'h0000);
    vecs[1]  = mk(1, 3, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0, 0,  1, 3, 16'hBEEF, 0, 1, 0, 16'h0000);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0, 3, 16'hBEEF, 0, 1, 0, 16'h0000);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 7, 0,  0, 3, 16'hBEEF, 0, 1, 1, 16'h0080);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 7, 16'h1234, 0, 0, 7, 0,  0, 3, 16'hBEEF, 1, 1, 1, 16'h0080);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 0,  1, 7, 16'h1234, 0, 1, 0, 16'h0000);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0,  0, 7, 16'h1234, 0, 1, 0, 16'h0002);
    vecs[7]  = mk(1,10, 16'h0A0A, 0, 0, 16'h0000, 1, 2, 1, 2,  1,10, 16'h0A0A, 0, 1, 1, 16'h0006);
    vecs[8]  = mk(1,11, 16'h0B0B, 1, 1, 16'h1111, 0, 0, 0, 0,  1,11, 16'h0B0B, 1, 1, 0, 16'h0006);
    vecs[9]  = mk(1,12, 16'h0C0C, 1, 2, 16'h2222, 0, 0, 0, 0,  1,12, 16'h0C0C, 2, 0, 0, 16'h0006);
    vecs[10] = mk(1,13, 16'h0D0D, 1, 5, 16'h5555, 0, 0, 0, 2,  1,13, 16'h0D0D, 2, 0, 1, 16'h0006);
    vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2,  1, 1, 16'h1111, 1, 1, 1, 16'h0004);
    vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 2,  1, 2, 16'h2222, 0, 1, 0, 16'h0000);
    vecs[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0, 2, 16'h2222, 0, 1, 0, 16'h0000);
    vecs[14] = mk(1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'hFFFF, 0, 1, 0, 16'h0000);
    vecs[15] = mk(0, 0, 16'h0000, 1, 0, 16'h7777, 0, 0, 0, 0,  0, 0, 16'hFFFF, 1, 1, 0, 16'h0000);
    vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h7777, 0, 1, 0, 16'h0000);
    vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 0, 0,  0, 0, 16'h7777, 0, 1, 0, 16'h0010);
    vecs[18] = mk(0, 0, 16'h0000, 1, 4, 16'h4444, 0, 0, 0, 0,  0, 0, 16'h7777, 1, 1, 0, 16'h0010);
    vecs[19] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 0, 4,  1, 4, 16'h4444, 0, 1, 1, 16'h0010);
    vecs[20] = mk(0, 0, 16'h0000, 1, 6, 16'h6666, 0, 0, 0, 0,  0, 4, 16'h4444, 1, 1, 0, 16'h0010);
    vecs[21] = mk(0, 0, 16'h0000, 1, 8, 16'h8888, 0, 0, 0, 0,  1, 6, 16'h6666, 1, 1, 0, 16'h0010);
    vecs[22] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  1, 8, 16'h8888, 0, 1, 0, 16'h0010);
    vecs[23] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0,  0, 8, 16'h8888, 0, 1, 0, 16'h0010);
    vecs[24] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 0,  0, 8, 16'h8888, 0, 1, 1, 16'h0030);
    vecs[25] = mk(1, 3, 16'h3333, 1, 9, 16'h9999, 0, 0, 5, 0,  1, 3, 16'h3333, 1, 1, 1, 16'h0030);

    rst = 1'b1;
    driveIdle();
    #12;
    check("reset_reg_write", 32'(reg_write), 32'd0);
    check("reset_ld_ready",  32'(ld_ready),  32'd0);
    check("reset_lq_count",  32'(lq_count),  32'd0);
    check("reset_pending",   32'(pending),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
    end

    // Reset asserted mid-cycle with one load queued and r5 pending
    driveIdle();
    chk_rs1 = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    check("midreset_reg_write", 32'(reg_write), 32'd0);
    check("midreset_rd",        32'(rd),        32'd0);
    check("midreset_rd_data",   32'(rd_data),   32'd0);
    check("midreset_lq_count",  32'(lq_count),  32'd0);
    check("midreset_pending",   32'(pending),   32'd0);
    check("midreset_stall",     32'(stall),     32'd0);
    check("midreset_ld_ready",  32'(ld_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ld_ready_before_edge", 32'(ld_ready), 32'd0);
    @(posedge clk);
    #1;
    check("release_ld_ready", 32'(ld_ready),  32'd1);
    check("release_lq_count", 32'(lq_count),  32'd0);
    check("release_no_write", 32'(reg_write), 32'd0);
    @(posedge clk);
    #1;
    check("discarded_no_write", 32'(reg_write), 32'd0);
    check("discarded_rd",       32'(rd),        32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
